// File: rtl/csr_file_if.sv
// CSR commit / trap / redirect bundle between the commit stage and the machine-mode CSR file.
// master drives commits and receives read data and redirects; slave is the CSR file.
interface csr_file_if #(
   parameter int XLEN = 64
);
   logic            csr_valid;
   logic [1:0]      csr_op;
   logic [11:0]     csr_addr;
   logic [XLEN-1:0] csr_wdata;
   logic            csr_src_zero;
   logic [XLEN-1:0] csr_r_data;
   logic            csr_illegal;
   logic            ecall;
   logic            mret;
   logic [XLEN-1:0] pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output csr_valid, csr_op, csr_addr, csr_wdata, csr_src_zero,
      output ecall, mret, pc,
      input  csr_r_data, csr_illegal, redirect_valid, redirect_pc
   );

   modport slave (
      input  csr_valid, csr_op, csr_addr, csr_wdata, csr_src_zero,
      input  ecall, mret, pc,
      output csr_r_data, csr_illegal, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV64 core: CSRRW/RS/RC access, ecall trap entry,
// mret return and a registered one-cycle PC redirect toward fetch.
module csr_file #(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000A_0000_1800
) (
   input logic       clk,
   input logic       rst_n,
   csr_file_if.slave bus
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   localparam int BIT_MIE    = 3;
   localparam int BIT_MPIE   = 7;
   localparam int BIT_MPP_LO = 11;
   localparam int BIT_MPP_HI = 12;

   localparam logic [XLEN-1:0] CAUSE_ECALL_M = XLEN'(11);

   typedef enum logic {
      IDLE,
      REDIRECT
   } state_t;

   state_t state, state_next;

   logic [XLEN-1:0] mstatus;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mscratch;
   logic [XLEN-1:0] mepc;
   logic [XLEN-1:0] mcause;
   logic [XLEN-1:0] mcycle;
   logic [XLEN-1:0] redirect_pc;

   logic [XLEN-1:0] old_value;
   logic [XLEN-1:0] new_value;
   logic            implemented;
   logic            write_en;
   logic            take_ecall;
   logic            take_mret;

   logic wr_mstatus;
   logic wr_mtvec;
   logic wr_mscratch;
   logic wr_mepc;
   logic wr_mcause;
   logic wr_mcycle;

   logic [XLEN-1:0] mstatus_trap;
   logic [XLEN-1:0] mstatus_ret;

   // Address decode and old-value mux; shared by the read port and the RMW path.
   always_comb begin
      old_value   = '0;
      implemented = 1'b1;
      case (bus.csr_addr)
         ADDR_MSTATUS:  old_value = mstatus;
         ADDR_MTVEC:    old_value = mtvec;
         ADDR_MSCRATCH: old_value = mscratch;
         ADDR_MEPC:     old_value = mepc;
         ADDR_MCAUSE:   old_value = mcause;
         ADDR_MCYCLE:   old_value = mcycle;
         default:       implemented = 1'b0;
      endcase
   end

   assign bus.csr_r_data  = (bus.csr_valid && implemented) ? old_value : '0;
   assign bus.csr_illegal = bus.csr_valid && !implemented;

   always_comb begin
      new_value = old_value;
      case (bus.csr_op)
         OP_RW:   new_value = bus.csr_wdata;
         OP_RS:   new_value = old_value | bus.csr_wdata;
         OP_RC:   new_value = old_value & ~bus.csr_wdata;
         default: new_value = old_value;
      endcase
   end

   // Trap entry stacks MIE into MPIE; return restores it. Both leave MPP at M-mode.
   always_comb begin
      mstatus_trap                         = mstatus;
      mstatus_trap[BIT_MPIE]               = mstatus[BIT_MIE];
      mstatus_trap[BIT_MIE]                = 1'b0;
      mstatus_trap[BIT_MPP_HI:BIT_MPP_LO]  = 2'b11;
      mstatus_ret                          = mstatus;
      mstatus_ret[BIT_MIE]                 = mstatus[BIT_MPIE];
      mstatus_ret[BIT_MPIE]                = 1'b1;
      mstatus_ret[BIT_MPP_HI:BIT_MPP_LO]   = 2'b11;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // REDIRECT flushes whatever commits alongside it; in IDLE ecall beats mret beats CSR writes.
   always_comb begin
      state_next = state;
      take_ecall = 1'b0;
      take_mret  = 1'b0;
      write_en   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.ecall) begin
               take_ecall = 1'b1;
               state_next = REDIRECT;
            end else if (bus.mret) begin
               take_mret  = 1'b1;
               state_next = REDIRECT;
            end else begin
               write_en = bus.csr_valid && implemented &&
                          ((bus.csr_op == OP_RW) ||
                           ((bus.csr_op != OP_NONE) && !bus.csr_src_zero));
            end
         end
         REDIRECT: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   assign wr_mstatus  = write_en && (bus.csr_addr == ADDR_MSTATUS);
   assign wr_mtvec    = write_en && (bus.csr_addr == ADDR_MTVEC);
   assign wr_mscratch = write_en && (bus.csr_addr == ADDR_MSCRATCH);
   assign wr_mepc     = write_en && (bus.csr_addr == ADDR_MEPC);
   assign wr_mcause   = write_en && (bus.csr_addr == ADDR_MCAUSE);
   assign wr_mcycle   = write_en && (bus.csr_addr == ADDR_MCYCLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus <= MSTATUS_RST;
      end else if (take_ecall) begin
         mstatus <= mstatus_trap;
      end else if (take_mret) begin
         mstatus <= mstatus_ret;
      end else if (wr_mstatus) begin
         mstatus <= new_value;
      end
   end

   // Only direct-mode trap vectors and 4-byte aligned return addresses are supported.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtvec    <= '0;
         mscratch <= '0;
      end else begin
         if (wr_mtvec) begin
            mtvec <= {new_value[XLEN-1:2], 2'b00};
         end
         if (wr_mscratch) begin
            mscratch <= new_value;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mepc   <= '0;
         mcause <= '0;
      end else if (take_ecall) begin
         mepc   <= {bus.pc[XLEN-1:2], 2'b00};
         mcause <= CAUSE_ECALL_M;
      end else begin
         if (wr_mepc) begin
            mepc <= {new_value[XLEN-1:2], 2'b00};
         end
         if (wr_mcause) begin
            mcause <= new_value;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcycle <= '0;
      end else if (wr_mcycle) begin
         mcycle <= new_value;
      end else begin
         mcycle <= mcycle + XLEN'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_pc <= '0;
      end else if (take_ecall) begin
         redirect_pc <= mtvec;
      end else if (take_mret) begin
         redirect_pc <= mepc;
      end
   end

   assign bus.redirect_valid = (state == REDIRECT);
   assign bus.redirect_pc    = redirect_pc;

endmodule

// File: tb/tb_csr_file.sv
// Randomized self-checking bench for csr_file against an address-keyed CSR model
// that applies the architectural access, trap and return rules each cycle.
module tb_csr_file;

   localparam int          XLEN        = 64;
   localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   csr_file_if #(.XLEN(XLEN)) bus ();

   csr_file #(
      .XLEN(XLEN),
      .MSTATUS_RST(MSTATUS_RST)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checkCount = 0;
   int errorCount = 0;

   logic [63:0] model [int];
   logic        modelRedirect;
   logic [63:0] modelRedirectPc;

   logic [63:0] lastRead;
   logic        lastIllegal;
   logic        lastRedirectValid;
   logic [63:0] lastRedirectPc;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      model.delete();
      model['h300] = MSTATUS_RST;
      model['h305] = 64'd0;
      model['h340] = 64'd0;
      model['h341] = 64'd0;
      model['h342] = 64'd0;
      model['hB00] = 64'd0;
      modelRedirect   = 1'b0;
      modelRedirectPc = 64'd0;
   endtask

   // Architectural effect of one clock edge, from the values held before that edge.
   task automatic modelStep(input logic valid, input logic [1:0] op, input logic [11:0] addr,
                            input logic [63:0] wdata, input logic srcZero,
                            input logic ecall, input logic mret, input logic [63:0] pc);
      int          a = int'(addr);
      logic [63:0] st = model['h300];
      logic [63:0] oldValue;
      logic [63:0] newValue;
      logic [63:0] cycleNext = model['hB00] + 64'd1;
      if (modelRedirect) begin
         modelRedirect = 1'b0;
      end else if (ecall) begin
         modelRedirectPc = model['h305];
         model['h341] = pc & ~64'd3;
         model['h342] = 64'd11;
         st[7] = st[3];
         st[3] = 1'b0;
         st[12:11] = 2'b11;
         model['h300] = st;
         modelRedirect = 1'b1;
      end else if (mret) begin
         modelRedirectPc = model['h341];
         st[3] = st[7];
         st[7] = 1'b1;
         st[12:11] = 2'b11;
         model['h300] = st;
         modelRedirect = 1'b1;
      end else if (valid && model.exists(a) && (op == 2'd1 || (op != 2'd0 && !srcZero))) begin
         oldValue = model[a];
         newValue = (op == 2'd1) ? wdata : (op == 2'd2) ? (oldValue | wdata) : (oldValue & ~wdata);
         if (a == 'h305 || a == 'h341) newValue[1:0] = 2'b00;
         model[a] = newValue;
         if (a == 'hB00) cycleNext = newValue;
      end
      model['hB00] = cycleNext;
   endtask

   // One cycle: drive, sample mid-cycle against the model, then advance past the edge.
   task automatic applyStimulus(input string tag, input logic valid, input logic [1:0] op,
                                input logic [11:0] addr, input logic [63:0] wdata, input logic srcZero,
                                input logic ecall, input logic mret, input logic [63:0] pc);
      int          a = int'(addr);
      logic [63:0] expData;
      bus.csr_valid    = valid;
      bus.csr_op       = op;
      bus.csr_addr     = addr;
      bus.csr_wdata    = wdata;
      bus.csr_src_zero = srcZero;
      bus.ecall        = ecall;
      bus.mret         = mret;
      bus.pc           = pc;
      #3;
      lastRead          = bus.csr_r_data;
      lastIllegal       = bus.csr_illegal;
      lastRedirectValid = bus.redirect_valid;
      lastRedirectPc    = bus.redirect_pc;
      if (!modelRedirect) begin
         expData = (valid && model.exists(a)) ? model[a] : 64'd0;
         checkOutput({tag, "/r_data"}, lastRead, expData);
         checkOutput({tag, "/illegal"}, {63'd0, lastIllegal}, {63'd0, valid && !model.exists(a)});
      end
      checkOutput({tag, "/redirect_valid"}, {63'd0, lastRedirectValid}, {63'd0, modelRedirect});
      if (modelRedirect) checkOutput({tag, "/redirect_pc"}, lastRedirectPc, modelRedirectPc);
      modelStep(valid, op, addr, wdata, srcZero, ecall, mret, pc);
      @(posedge clk);
      #1;
   endtask

   task automatic readCsr(input string tag, input logic [11:0] addr);
      applyStimulus(tag, 1'b1, 2'd0, addr, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
   endtask

   task automatic writeCsr(input string tag, input logic [1:0] op, input logic [11:0] addr,
                           input logic [63:0] wdata, input logic srcZero);
      applyStimulus(tag, 1'b1, op, addr, wdata, srcZero, 1'b0, 1'b0, 64'd0);
   endtask

   task automatic idleCycle(input string tag);
      applyStimulus(tag, 1'b0, 2'd0, 12'h000, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      bus.csr_valid = 1'b0; bus.csr_op = 2'd0; bus.csr_addr = 12'h0; bus.csr_wdata = 64'd0;
      bus.csr_src_zero = 1'b0; bus.ecall = 1'b0; bus.mret = 1'b0; bus.pc = 64'd0;
      repeat (2) @(posedge clk);
      #1;
      resetModel();
      rst_n = 1'b1;
   endtask

   logic [11:0] addrPool [8] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'h7C0, 12'h301};

   initial begin
      applyReset();
      checkOutput("reset_redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
      checkOutput("reset_redirect_pc", bus.redirect_pc, 64'd0);
      readCsr("reset_mstatus", 12'h300);
      checkOutput("reset_mstatus_lit", lastRead, 64'h0000_000A_0000_1800);
      readCsr("reset_mtvec", 12'h305);
      checkOutput("reset_mtvec_lit", lastRead, 64'd0);

      writeCsr("rw_mscratch", 2'd1, 12'h340, 64'hF0, 1'b0);
      checkOutput("rw_old", lastRead, 64'h0);
      writeCsr("rs_mscratch", 2'd2, 12'h340, 64'h0F, 1'b0);
      checkOutput("rs_old", lastRead, 64'hF0);
      writeCsr("rc_mscratch", 2'd3, 12'h340, 64'h3C, 1'b0);
      checkOutput("rc_old", lastRead, 64'hFF);
      readCsr("mscratch_final", 12'h340);
      checkOutput("mscratch_final_lit", lastRead, 64'hC3);
      writeCsr("rs_src_zero", 2'd2, 12'h340, 64'hFF, 1'b1);
      readCsr("mscratch_kept", 12'h340);
      checkOutput("mscratch_kept_lit", lastRead, 64'hC3);

      writeCsr("rw_mtvec", 2'd1, 12'h305, 64'h8000_0007, 1'b0);
      readCsr("mtvec_masked", 12'h305);
      checkOutput("mtvec_masked_lit", lastRead, 64'h8000_0004);
      writeCsr("illegal_write", 2'd1, 12'h7C0, 64'h1234, 1'b0);
      checkOutput("illegal_flag", {63'd0, lastIllegal}, 64'd1);
      checkOutput("illegal_data", lastRead, 64'd0);
      readCsr("mscratch_after_illegal", 12'h340);

      writeCsr("set_mtvec", 2'd1, 12'h305, 64'h8000_0100, 1'b0);
      writeCsr("set_mie", 2'd2, 12'h300, 64'h8, 1'b0);
      applyStimulus("ecall", 1'b0, 2'd0, 12'h0, 64'd0, 1'b0, 1'b1, 1'b0, 64'h8000_0040);
      idleCycle("ecall_redirect");
      checkOutput("ecall_pulse", {63'd0, lastRedirectValid}, 64'd1);
      checkOutput("ecall_target", lastRedirectPc, 64'h8000_0100);
      readCsr("ecall_mepc", 12'h341);
      checkOutput("ecall_mepc_lit", lastRead, 64'h8000_0040);
      readCsr("ecall_mcause", 12'h342);
      checkOutput("ecall_mcause_lit", lastRead, 64'd11);
      readCsr("ecall_mstatus", 12'h300);
      checkOutput("ecall_mie", {63'd0, lastRead[3]}, 64'd0);
      checkOutput("ecall_mpie", {63'd0, lastRead[7]}, 64'd1);

      applyStimulus("mret", 1'b0, 2'd0, 12'h0, 64'd0, 1'b0, 1'b0, 1'b1, 64'h0);
      idleCycle("mret_redirect");
      checkOutput("mret_target", lastRedirectPc, 64'h8000_0040);
      readCsr("mret_mstatus", 12'h300);
      checkOutput("mret_mie", {63'd0, lastRead[3]}, 64'd1);
      checkOutput("mret_mpie", {63'd0, lastRead[7]}, 64'd1);

      applyStimulus("ecall_and_mret", 1'b1, 2'd1, 12'h340, 64'h55, 1'b0, 1'b1, 1'b1, 64'h8000_0200);
      applyStimulus("ecall_in_redirect", 1'b0, 2'd0, 12'h0, 64'd0, 1'b0, 1'b1, 1'b0, 64'h9990);
      checkOutput("both_target", lastRedirectPc, 64'h8000_0100);
      idleCycle("no_second_pulse");
      checkOutput("no_second_pulse_lit", {63'd0, lastRedirectValid}, 64'd0);
      readCsr("both_mepc", 12'h341);
      checkOutput("both_mepc_lit", lastRead, 64'h8000_0200);
      readCsr("dropped_write", 12'h340);
      checkOutput("dropped_write_lit", lastRead, 64'hC3);

      writeCsr("mcycle_ones", 2'd1, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      readCsr("mcycle_written", 12'hB00);
      checkOutput("mcycle_written_lit", lastRead, 64'hFFFF_FFFF_FFFF_FFFF);
      readCsr("mcycle_wrap", 12'hB00);
      checkOutput("mcycle_wrap_lit", lastRead, 64'd0);

      applyStimulus("ecall_pre_reset", 1'b0, 2'd0, 12'h0, 64'd0, 1'b0, 1'b1, 1'b0, 64'h8000_0300);
      checkOutput("pulse_before_reset", {63'd0, bus.redirect_valid}, 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("pulse_dropped_by_reset", {63'd0, bus.redirect_valid}, 64'd0);
      applyReset();
      readCsr("post_reset_mstatus", 12'h300);
      checkOutput("post_reset_mstatus_lit", lastRead, MSTATUS_RST);
      idleCycle("post_reset_idle");

      for (int i = 0; i < 600; i++) begin
         logic [11:0] a;
         a = addrPool[$urandom_range(0, 7)];
         applyStimulus("random", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a,
                       {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
                       {$urandom, $urandom});
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
